// File: rtl/aurora_20g_chk_ctrl.sv
// Run sequencer for the 20G Aurora ADC pattern checker: clear, settle, gated
// capture window with timeout, then grade the run and keep saturating stats.
module aurora_20g_chk_ctrl #(
  parameter int unsigned CLR_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned STAT_WD    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_en,
  input  logic               clr_stats,
  input  logic [31:0]        win_len,
  input  logic [31:0]        timeout,
  input  logic [31:0]        err_thr,
  input  logic               adc_vld,
  input  logic [31:0]        suc_cnt,
  input  logic [31:0]        err_cnt,
  output logic               chk_rst,
  output logic               chk_vld,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               to_flag,
  output logic [31:0]        last_suc,
  output logic [31:0]        last_err,
  output logic [STAT_WD-1:0] run_cnt,
  output logic [STAT_WD-1:0] fail_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SETTLE,
    ST_RUN,
    ST_EVAL,
    ST_DONE
  } state_t;

  localparam logic [31:0]        CLR_LAST    = 32'(CLR_CYC - 1);
  localparam logic [31:0]        SETTLE_LAST = 32'(SETTLE_CYC - 1);
  localparam logic [STAT_WD-1:0] STAT_ONE    = STAT_WD'(1);

  state_t             state_q, state_d;
  logic [31:0]        cyc_q, cyc_d;
  logic [31:0]        beat_q, beat_d;
  logic [31:0]        win_len_q, win_len_d;
  logic [31:0]        timeout_q, timeout_d;
  logic [31:0]        err_thr_q, err_thr_d;
  logic               to_int_q, to_int_d;
  logic               pass_q, pass_d;
  logic               to_flag_q, to_flag_d;
  logic [31:0]        last_suc_q, last_suc_d;
  logic [31:0]        last_err_q, last_err_d;
  logic [STAT_WD-1:0] run_cnt_q, run_cnt_d;
  logic [STAT_WD-1:0] fail_cnt_q, fail_cnt_d;

  logic               abort_act;
  logic [32:0]        sum_33;

  assign abort_act = abort && (state_q != ST_IDLE);
  assign sum_33    = {1'b0, suc_cnt} + {1'b0, err_cnt};

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    beat_d     = beat_q;
    win_len_d  = win_len_q;
    timeout_d  = timeout_q;
    err_thr_d  = err_thr_q;
    to_int_d   = to_int_q;
    pass_d     = pass_q;
    to_flag_d  = to_flag_q;
    last_suc_d = last_suc_q;
    last_err_d = last_err_q;
    run_cnt_d  = run_cnt_q;
    fail_cnt_d = fail_cnt_q;

    // Abort leaves results and statistics untouched; only the state collapses.
    if (abort_act) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (win_len != 32'd0)) begin
            state_d   = ST_CLR;
            cyc_d     = 32'd0;
            win_len_d = win_len;
            timeout_d = timeout;
            err_thr_d = err_thr;
          end
        end
        ST_CLR: begin
          if (cyc_q == CLR_LAST) begin
            state_d = ST_SETTLE;
            cyc_d   = 32'd0;
          end else begin
            cyc_d = cyc_q + 32'd1;
          end
        end
        ST_SETTLE: begin
          if (cyc_q == SETTLE_LAST) begin
            state_d = ST_RUN;
            cyc_d   = 32'd0;
            beat_d  = 32'd0;
          end else begin
            cyc_d = cyc_q + 32'd1;
          end
        end
        ST_RUN: begin
          cyc_d = cyc_q + 32'd1;
          if (adc_vld) begin
            beat_d = beat_q + 32'd1;
          end
          // A final beat landing on the timeout cycle still counts as a full window.
          if (adc_vld && (beat_q + 32'd1 == win_len_q)) begin
            state_d  = ST_EVAL;
            cyc_d    = 32'd0;
            to_int_d = 1'b0;
          end else if ((timeout_q != 32'd0) && (cyc_q == timeout_q - 32'd1)) begin
            state_d  = ST_EVAL;
            cyc_d    = 32'd0;
            to_int_d = 1'b1;
          end
        end
        ST_EVAL: begin
          if (cyc_q == 32'd1) begin
            state_d    = ST_DONE;
            last_suc_d = suc_cnt;
            last_err_d = err_cnt;
            to_flag_d  = to_int_q;
            pass_d     = !to_int_q && (err_cnt <= err_thr_q) && (sum_33 == {1'b0, win_len_q});
          end else begin
            cyc_d = cyc_q + 32'd1;
          end
        end
        ST_DONE: begin
          if (run_cnt_q != '1) begin
            run_cnt_d = run_cnt_q + STAT_ONE;
          end
          if (!pass_q && (fail_cnt_q != '1)) begin
            fail_cnt_d = fail_cnt_q + STAT_ONE;
          end
          if (loop_en) begin
            state_d   = ST_CLR;
            cyc_d     = 32'd0;
            win_len_d = win_len;
            timeout_d = timeout;
            err_thr_d = err_thr;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (clr_stats) begin
      run_cnt_d  = '0;
      fail_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      beat_q     <= '0;
      win_len_q  <= '0;
      timeout_q  <= '0;
      err_thr_q  <= '0;
      to_int_q   <= 1'b0;
      pass_q     <= 1'b0;
      to_flag_q  <= 1'b0;
      last_suc_q <= '0;
      last_err_q <= '0;
      run_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      beat_q     <= beat_d;
      win_len_q  <= win_len_d;
      timeout_q  <= timeout_d;
      err_thr_q  <= err_thr_d;
      to_int_q   <= to_int_d;
      pass_q     <= pass_d;
      to_flag_q  <= to_flag_d;
      last_suc_q <= last_suc_d;
      last_err_q <= last_err_d;
      run_cnt_q  <= run_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign chk_rst  = rst || (state_q == ST_CLR) || abort_act;
  assign chk_vld  = adc_vld && (state_q == ST_RUN);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE) && !abort;
  assign pass     = pass_q;
  assign to_flag  = to_flag_q;
  assign last_suc = last_suc_q;
  assign last_err = last_err_q;
  assign run_cnt  = run_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_aurora_20g_chk_ctrl.sv
// Scoreboard bench for aurora_20g_chk_ctrl: a run-level reference model predicts
// each run's outcome and DONE cycle; a monitor pops predictions on every done pulse.
module tb_aurora_20g_chk_ctrl;

  localparam int CLR_CYC    = 4;
  localparam int SETTLE_CYC = 16;
  localparam int STAT_WD    = 4;
  localparam int RUN_OFF    = 1 + CLR_CYC + SETTLE_CYC;
  localparam int PAT_LEN    = 1024;
  localparam int STAT_MAX   = (1 << STAT_WD) - 1;

  logic clk = 1'b0;
  logic rst, start, abort, loop_en, clr_stats, adc_vld;
  logic [31:0] win_len, timeout, err_thr;
  logic [31:0] suc_cnt = '0;
  logic [31:0] err_cnt = '0;
  logic chk_rst, chk_vld, busy, done, pass, to_flag;
  logic [31:0] last_suc, last_err;
  logic [STAT_WD-1:0] run_cnt, fail_cnt;

  aurora_20g_chk_ctrl #(
    .CLR_CYC   (CLR_CYC),
    .SETTLE_CYC(SETTLE_CYC),
    .STAT_WD   (STAT_WD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .loop_en  (loop_en),
    .clr_stats(clr_stats),
    .win_len  (win_len),
    .timeout  (timeout),
    .err_thr  (err_thr),
    .adc_vld  (adc_vld),
    .suc_cnt  (suc_cnt),
    .err_cnt  (err_cnt),
    .chk_rst  (chk_rst),
    .chk_vld  (chk_vld),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .to_flag  (to_flag),
    .last_suc (last_suc),
    .last_err (last_err),
    .run_cnt  (run_cnt),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int done_cyc;
    bit pass;
    bit tof;
    int suc;
    int err;
    int run;
    int fail;
  } exp_t;

  exp_t sb_q[$];
  bit   pat[PAT_LEN];
  bit   cor[128];
  int   base_p   = 0;
  int   exp_run  = 0;
  int   exp_fail = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  // Checker stand-in: registered counts, beat index selects corrupted beats.
  always @(posedge clk) begin
    logic [6:0] bidx;
    bidx = 7'(suc_cnt + err_cnt);
    if (chk_rst) begin
      suc_cnt <= '0;
      err_cnt <= '0;
    end else if (chk_vld) begin
      if (cor[bidx]) err_cnt <= err_cnt + 32'd1;
      else           suc_cnt <= suc_cnt + 32'd1;
    end
  end

  // Link beat source replays the pattern relative to the current base cycle.
  initial begin
    adc_vld = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      adc_vld = ((cyc - base_p) >= 0 && (cyc - base_p) < PAT_LEN) ? pat[cyc - base_p] : 1'b0;
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_to(input int p);
    while (cyc < p) @(negedge clk);
  endtask

  task automatic fill_pat(input int mode);
    for (int i = 0; i < PAT_LEN; i++) begin
      case (mode)
        0:       pat[i] = 1'b0;
        1:       pat[i] = 1'b1;
        2:       pat[i] = (i % 4 == 1);
        default: pat[i] = ($urandom % 3) != 0;
      endcase
    end
  endtask

  task automatic clear_cor();
    for (int i = 0; i < 128; i++) cor[i] = 1'b0;
  endtask

  // Reference model: walk the window beat by beat from the first RUN cycle.
  task automatic push_run(input int p, input int wl, input int tmo, input int thr,
                          input bit clr_at_done, output int done_p);
    exp_t e;
    int   beats = 0;
    int   k     = 0;
    int   nsuc  = 0;
    int   idx;
    bit   v;
    bit   tof   = 1'b0;
    forever begin
      idx = p - base_p + RUN_OFF + k;
      v   = (idx >= 0 && idx < PAT_LEN) ? pat[idx] : 1'b0;
      if (v) begin
        if (!cor[beats % 128]) nsuc++;
        beats++;
      end
      if (v && beats == wl) break;
      if (tmo != 0 && k + 1 == tmo) begin
        tof = 1'b1;
        break;
      end
      if (k > 4000) break;
      k++;
    end
    e.suc      = nsuc;
    e.err      = beats - nsuc;
    e.tof      = tof;
    e.pass     = !tof && (e.err <= thr) && (beats == wl);
    e.done_cyc = p + RUN_OFF + (k + 1) + 2;
    exp_run    = (exp_run < STAT_MAX) ? exp_run + 1 : STAT_MAX;
    if (!e.pass) exp_fail = (exp_fail < STAT_MAX) ? exp_fail + 1 : STAT_MAX;
    if (clr_at_done) begin
      exp_run  = 0;
      exp_fail = 0;
    end
    e.run  = exp_run;
    e.fail = exp_fail;
    sb_q.push_back(e);
    done_p = e.done_cyc;
  endtask

  task automatic applyStimulus(input int wl, input int tmo, input int thr, output int p);
    @(negedge clk);
    p       = cyc;
    base_p  = cyc;
    win_len = wl;
    timeout = tmo;
    err_thr = thr;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Monitor: per-run beat/clear counts and scoreboard pops on done.
  initial begin
    exp_t e;
    int   vld_seen = 0;
    int   rst_seen = 0;
    bit   pend     = 1'b0;
    int   pr       = 0;
    int   pf       = 0;
    forever begin
      @(negedge clk);
      #2;
      if (pend) begin
        checkOutput("run_cnt", run_cnt, pr);
        checkOutput("fail_cnt", fail_cnt, pf);
        pend = 1'b0;
      end
      if (!busy) begin
        vld_seen = 0;
        rst_seen = 0;
      end else begin
        if (chk_vld) vld_seen++;
        if (chk_rst) rst_seen++;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_done_sb_size", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          checkOutput("done_cycle", cyc, e.done_cyc);
          checkOutput("pass", pass, e.pass);
          checkOutput("to_flag", to_flag, e.tof);
          checkOutput("last_suc", last_suc, e.suc);
          checkOutput("last_err", last_err, e.err);
          checkOutput("chk_vld_beats", vld_seen, e.suc + e.err);
          checkOutput("chk_rst_cycles", rst_seen, CLR_CYC);
          pend = 1'b1;
          pr   = e.run;
          pf   = e.fail;
        end
        vld_seen = 0;
        rst_seen = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int p, d, d1, d2, d3;
    int ds[17];
    int wl, tmo, thr;

    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; clr_stats = 1'b0;
    win_len = '0; timeout = '0; err_thr = '0;
    fill_pat(0);
    clear_cor();
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_chk_rst", chk_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_pass", pass, 0);
    checkOutput("reset_run_cnt", run_cnt, 0);
    checkOutput("reset_chk_rst_low", chk_rst, 0);

    // Single error-free run; a second start mid-run must be dropped.
    fill_pat(1);
    applyStimulus(8, 0, 0, p);
    push_run(p, 8, 0, 0, 1'b0, d);
    wait_to(p + 10);
    win_len = 3;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_to(d + 1);
    #2;
    checkOutput("idle_after_single", busy, 0);
    checkOutput("single_last_suc", last_suc, 8);

    // Three corrupted beats against two thresholds.
    cor[2] = 1'b1; cor[5] = 1'b1; cor[11] = 1'b1;
    applyStimulus(16, 0, 2, p);
    push_run(p, 16, 0, 2, 1'b0, d);
    wait_to(d + 3);
    applyStimulus(16, 0, 3, p);
    push_run(p, 16, 0, 3, 1'b0, d);
    wait_to(d + 3);
    clear_cor();

    // Timeout with a sparse beat stream.
    fill_pat(2);
    applyStimulus(100, 50, 0, p);
    push_run(p, 100, 50, 0, 1'b0, d);
    wait_to(d + 1);
    #2;
    checkOutput("timeout_last_suc", last_suc, 13);
    checkOutput("timeout_flag", to_flag, 1);
    wait_to(d + 3);

    // Zero-length window is never accepted.
    fill_pat(1);
    applyStimulus(0, 0, 0, p);
    repeat (2) @(negedge clk);
    #2;
    checkOutput("win_len0_busy", busy, 0);

    // Last beat coincides with timeout: completion wins.
    applyStimulus(1, 1, 0, p);
    push_run(p, 1, 1, 0, 1'b0, d);
    wait_to(d + 3);

    // clr_stats on the done cycle beats the increment.
    applyStimulus(2, 0, 0, p);
    push_run(p, 2, 0, 0, 1'b1, d);
    wait_to(d);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    wait_to(d + 3);

    // Loop three runs, then abort the fourth in RUN.
    loop_en = 1'b1;
    applyStimulus(4, 0, 0, p);
    push_run(p, 4, 0, 0, 1'b0, d1);
    push_run(d1, 4, 0, 0, 1'b0, d2);
    push_run(d2, 4, 0, 0, 1'b0, d3);
    wait_to(d3 + RUN_OFF + 1);
    abort = 1'b1;
    #2;
    checkOutput("abort_chk_rst", chk_rst, 1);
    checkOutput("abort_no_done", done, 0);
    @(negedge clk);
    abort   = 1'b0;
    loop_en = 1'b0;
    #2;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_chk_rst_drop", chk_rst, 0);
    checkOutput("loop_run_cnt", run_cnt, exp_run);
    repeat (40) @(negedge clk);

    // Randomized windows, beat streams, corruption and timeouts.
    for (int r = 0; r < 6; r++) begin
      fill_pat(3);
      for (int i = 0; i < 128; i++) cor[i] = ($urandom % 8) == 0;
      wl  = $urandom_range(1, 40);
      tmo = ($urandom % 2) ? $urandom_range(1, 60) : 0;
      thr = $urandom_range(0, 3);
      applyStimulus(wl, tmo, thr, p);
      push_run(p, wl, tmo, thr, 1'b0, d);
      wait_to(d + 3);
    end
    clear_cor();

    // Saturation: 17 failing looped runs on a 4-bit counter.
    fill_pat(1);
    loop_en = 1'b1;
    applyStimulus(2, 1, 5, p);
    push_run(p, 2, 1, 5, 1'b0, ds[0]);
    for (int i = 1; i < 17; i++) push_run(ds[i-1], 2, 1, 5, 1'b0, ds[i]);
    wait_to(ds[16] - 2);
    loop_en = 1'b0;
    wait_to(ds[16] + 3);
    #2;
    checkOutput("sat_run_cnt", run_cnt, STAT_MAX);
    checkOutput("sat_fail_cnt", fail_cnt, STAT_MAX);

    // Reset in the middle of RUN.
    applyStimulus(50, 0, 0, p);
    wait_to(p + RUN_OFF + 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_run  = 0;
    exp_fail = 0;
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_chk_vld", chk_vld, 0);
    checkOutput("rst_run_cnt", run_cnt, 0);
    checkOutput("rst_fail_cnt", fail_cnt, 0);
    checkOutput("rst_last_suc", last_suc, 0);
    checkOutput("rst_to_flag", to_flag, 0);
    checkOutput("rst_pass", pass, 0);
    repeat (5) @(negedge clk);

    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
